id_stage: RTL and testbench
===========================

# id_stage

Instruction Decode stage of the RISC-V RV32I 5-stage pipeline, directly downstream of the IF stage's IF/ID register. It decodes the fetched instruction, generates the immediate and control bundle, and reads a 32×32 register file that has write-through bypass from WB. It detects load-use hazards, stalling IF and inserting a bubble, and it registers everything into the ID/EX pipeline register consumed by EX.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 32, PC width
- REG_ADDR_WIDTH, 5, register index width

One clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- instruction  in  32  from IF/ID
- PC  in  32  from IF/ID
- PC_plus_4  in  32  from IF/ID
- flush  in  1  EX branch/jump taken; discard the instruction in ID
- wb_en  in  1  WB register write enable
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB write data
- load_use_stall  out  1  combinational; drives IF stall
- ex_PC, ex_PC_plus_4  out  32  registered PC values
- ex_rs1_data, ex_rs2_data, ex_imm  out  32  operands and sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices, for forwarding
- ex_funct3  out  3  branch condition / load-store size
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- ex_alu_src_imm, ex_op_a_pc  out  1  ALU B = imm; ALU A = PC
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal  out  1  control bits
- ex_wb_sel  out  2  0 ALU, 1 memory, 2 PC+4

## Operation
- **Register file:**
  - 32 entries.
  - Written at posedge when wb_en && wb_rd≠0; x0 is never written.
  - Reads are combinational; x0 reads 0.
  - Bypass: if wb_en && wb_rd==rsN && rsN≠0, the read returns wb_data in the same cycle.
  - rst clears all entries.
- **Decode by opcode:**
  - LUI: imm U, PASS_B, reg_write.
  - AUIPC: op_a_pc, imm U, ADD, reg_write.
  - JAL: jump, imm J, wb_sel=2, reg_write.
  - JALR: jump, jalr, imm I, wb_sel=2, reg_write.
  - BRANCH: branch, imm B, SUB.
  - LOAD: mem_read, imm I, ADD, wb_sel=1, reg_write.
  - STORE: mem_write, imm S, ADD.
  - OP-IMM: imm I; alu_op from funct3, with funct7[5] selecting SRA. ADDI never produces SUB.
  - OP: alu_op from funct3 and funct7[5].
  - FENCE: all control bits 0 (NOP).
  - SYSTEM or any other opcode: ex_illegal=1, all other control bits 0.
- **Immediates:** standard RV32I I/S/B/U/J formats, sign-extended from instruction[31]. B and J immediates have bit 0 = 0.
- **Register usage for hazard check:**
  - rs1 is used by every opcode except LUI, AUIPC, JAL, FENCE and illegal.
  - rs2 is used by OP, STORE and BRANCH.
- **Load-use hazard:** hazard = ex_mem_read && ex_rd≠0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)).
- **load_use_stall = hazard && !flush.** Flush masks the stall so that IF (stall outranks branch) can still redirect.
- **ID/EX update priority at posedge:**
  1. rst: all outputs 0.
  2. flush: bubble.
  3. hazard: bubble.
  4. Otherwise: load the decoded bundle.
- **Bubble:** every ID/EX field loaded with 0, including rd=0 and all control bits 0.

## Timing
- Decode, register read and hazard detection are combinational in the ID cycle.
- ID/EX outputs are valid one cycle after the instruction is present at the inputs. Latency is 1.
- load_use_stall is combinational from the instruction and the current ID/EX fields. It asserts in the same cycle the hazard exists.
- During a stall, IF holds IF/ID, so the same instruction is re-decoded the next cycle. At that point the hazard has cleared because the bubble's ex_mem_read=0. Stall length is exactly 1 cycle.
- A WB write and an ID read of the same register in the same cycle returns the new value; there is no 1-cycle stale window.
- rst asserted mid-operation: at the next posedge all outputs and registers are 0, and load_use_stall becomes 0 once the ID/EX fields are cleared.
- Reset value of every output is 0. load_use_stall is 0 after reset.

## Test plan
- **Immediate and ALU decode:** instruction 0xFFF00093 (addi x1,x0,-1) → next cycle ex_imm=0xFFFFFFFF, ex_alu_op=0, ex_alu_src_imm=1, ex_reg_write=1, ex_rd=1.
- **Bypass and x0 writes:**
  - wb_en=1, wb_rd=5, wb_data=0xDEADBEEF with add x6,x5,x0 in ID in the same cycle → ex_rs1_data=0xDEADBEEF.
  - A write to x0 → a later read of x0 returns 0.
- **Load-use hazard:** lw x3,0(x1) followed by add x4,x3,x2.
  - In the cycle the add is in ID: load_use_stall=1.
  - Next cycle: ID/EX is a bubble (ex_reg_write=0, ex_rd=0) and load_use_stall=0.
  - Cycle after: the add is issued.
- **Flush and stall together:** flush=1 in the same cycle as a load-use hazard → load_use_stall=0 and ID/EX becomes a bubble.
- **Illegal and branch immediate:**
  - instruction 0x00000073 (ecall) → ex_illegal=1, ex_reg_write=0.
  - beq offset -4 (0xFE000EE3) → ex_imm=0xFFFFFFFC, ex_branch=1.
- **Reset mid-stream:** assert rst while ID/EX holds a valid load → next cycle all outputs 0 and the register file reads 0 for x1..x31.

Source files
------------

// File: rtl/id_stage.sv
// RV32I instruction decode stage: decoder, immediate generator, register file with
// same-cycle WB bypass, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instruction,
  input  logic [ADDR_WIDTH-1:0]     PC,
  input  logic [ADDR_WIDTH-1:0]     PC_plus_4,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      load_use_stall,
  output logic [ADDR_WIDTH-1:0]     ex_PC,
  output logic [ADDR_WIDTH-1:0]     ex_PC_plus_4,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [2:0]                ex_funct3,
  output logic [3:0]                ex_alu_op,
  output logic                      ex_alu_src_imm,
  output logic                      ex_op_a_pc,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_reg_write,
  output logic                      ex_branch,
  output logic                      ex_jump,
  output logic                      ex_jalr,
  output logic                      ex_illegal,
  output logic [1:0]                ex_wb_sel
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8,   ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     pc;
    logic [ADDR_WIDTH-1:0]     pc4;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic [3:0]                alu_op;
    logic                      alu_src_imm;
    logic                      op_a_pc;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      branch;
    logic                      jump;
    logic                      jalr;
    logic                      illegal;
    logic [1:0]                wb_sel;
  } idex_t;

  // alt selects SUB for ADD and SRA for SRL; callers decide when alt is meaningful
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0]     rf_q [2**REG_ADDR_WIDTH];
  idex_t                     idex_q, idex_d;
  logic [6:0]                opcode_s;
  logic [REG_ADDR_WIDTH-1:0] rs1_s, rs2_s;
  logic [DATA_WIDTH-1:0]     rs1_data_s, rs2_data_s;
  logic [31:0]               imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic                      use_rs1_s, use_rs2_s, hazard_s;

  assign opcode_s = instruction[6:0];
  assign rs1_s    = instruction[19:15];
  assign rs2_s    = instruction[24:20];
  assign imm_i_s  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b_s  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u_s  = {instruction[31:12], 12'h000};
  assign imm_j_s  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

  // Register file reads: x0 is hard zero, a WB write in flight wins over stored data
  always_comb begin
    if (rs1_s == '0) rs1_data_s = '0;
    else if (wb_en && (wb_rd == rs1_s)) rs1_data_s = wb_data;
    else rs1_data_s = rf_q[rs1_s];
    if (rs2_s == '0) rs2_data_s = '0;
    else if (wb_en && (wb_rd == rs2_s)) rs2_data_s = wb_data;
    else rs2_data_s = rf_q[rs2_s];
  end

  // Register file write port; x0 is never stored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      rf_q[wb_rd] <= wb_data;
    end else begin
      rf_q[0] <= '0;
    end
  end

  // Opcode decode into the next ID/EX bundle plus source-register usage flags
  always_comb begin
    idex_d          = '0;
    use_rs1_s       = 1'b0;
    use_rs2_s       = 1'b0;
    idex_d.pc       = PC;
    idex_d.pc4      = PC_plus_4;
    idex_d.rs1_data = rs1_data_s;
    idex_d.rs2_data = rs2_data_s;
    idex_d.rs1      = rs1_s;
    idex_d.rs2      = rs2_s;
    idex_d.rd       = instruction[11:7];
    idex_d.funct3   = instruction[14:12];
    case (opcode_s)
      OPC_LUI: begin
        idex_d.imm = imm_u_s; idex_d.alu_op = ALU_PASS_B;
        idex_d.alu_src_imm = 1'b1; idex_d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        idex_d.imm = imm_u_s; idex_d.alu_op = ALU_ADD; idex_d.op_a_pc = 1'b1;
        idex_d.alu_src_imm = 1'b1; idex_d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        idex_d.imm = imm_j_s; idex_d.jump = 1'b1;
        idex_d.wb_sel = 2'd2; idex_d.reg_write = 1'b1;
      end
      OPC_JALR: begin
        idex_d.imm = imm_i_s; idex_d.jump = 1'b1; idex_d.jalr = 1'b1;
        idex_d.alu_src_imm = 1'b1; idex_d.wb_sel = 2'd2; idex_d.reg_write = 1'b1;
        use_rs1_s = 1'b1;
      end
      OPC_BRANCH: begin
        idex_d.imm = imm_b_s; idex_d.alu_op = ALU_SUB; idex_d.branch = 1'b1;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OPC_LOAD: begin
        idex_d.imm = imm_i_s; idex_d.alu_op = ALU_ADD; idex_d.alu_src_imm = 1'b1;
        idex_d.mem_read = 1'b1; idex_d.wb_sel = 2'd1; idex_d.reg_write = 1'b1;
        use_rs1_s = 1'b1;
      end
      OPC_STORE: begin
        idex_d.imm = imm_s_s; idex_d.alu_op = ALU_ADD; idex_d.alu_src_imm = 1'b1;
        idex_d.mem_write = 1'b1;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7[5] only matters for shifts here so ADDI never turns into SUB
        idex_d.imm = imm_i_s; idex_d.alu_src_imm = 1'b1; idex_d.reg_write = 1'b1;
        idex_d.alu_op = alu_fn(instruction[14:12],
                               instruction[30] && (instruction[14:12] == 3'b101));
        use_rs1_s = 1'b1;
      end
      OPC_OP: begin
        idex_d.alu_op = alu_fn(instruction[14:12], instruction[30]);
        idex_d.reg_write = 1'b1;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OPC_FENCE: begin
        idex_d.alu_op = ALU_ADD;
      end
      default: begin
        idex_d.illegal = 1'b1;
      end
    endcase
  end

  assign hazard_s = idex_q.mem_read && (idex_q.rd != '0) &&
                    ((use_rs1_s && (idex_q.rd == rs1_s)) || (use_rs2_s && (idex_q.rd == rs2_s)));
  assign load_use_stall = hazard_s && !flush;

  // ID/EX register: reset, then flush, then load-use bubble, else the new bundle
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else if (flush) idex_q <= '0;
    else if (hazard_s) idex_q <= '0;
    else idex_q <= idex_d;
  end

  assign ex_PC          = idex_q.pc;
  assign ex_PC_plus_4   = idex_q.pc4;
  assign ex_rs1_data    = idex_q.rs1_data;
  assign ex_rs2_data    = idex_q.rs2_data;
  assign ex_imm         = idex_q.imm;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_rd          = idex_q.rd;
  assign ex_funct3      = idex_q.funct3;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_alu_src_imm = idex_q.alu_src_imm;
  assign ex_op_a_pc     = idex_q.op_a_pc;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_branch      = idex_q.branch;
  assign ex_jump        = idex_q.jump;
  assign ex_jalr        = idex_q.jalr;
  assign ex_illegal     = idex_q.illegal;
  assign ex_wb_sel      = idex_q.wb_sel;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push hand-computed ID/EX
// bundles and stall values; a negedge monitor pops and compares them.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc, pc4, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm, op_a_pc, mem_read, mem_write, reg_write;
    logic        branch, jump, jalr, illegal;
    logic [1:0]  wb_sel;
  } bundle_t;

  typedef struct {
    logic    chk_stall;
    logic    exp_stall;
    logic    chk_ex;
    bundle_t exp;
    string   name;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, flush, wb_en, load_use_stall;
  logic [31:0] instruction, PC, PC_plus_4, wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] ex_PC, ex_PC_plus_4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_op_a_pc, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_jalr, ex_illegal;
  logic [1:0]  ex_wb_sel;

  item_t sb_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PC_plus_4(PC_plus_4),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use_stall(load_use_stall), .ex_PC(ex_PC), .ex_PC_plus_4(ex_PC_plus_4),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_op_a_pc(ex_op_a_pc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal),
    .ex_wb_sel(ex_wb_sel)
  );

  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                                 input logic [4:0] rs1, rs2, rd,
                                 input logic [2:0] f3, input logic [3:0] alu);
    bundle_t b;
    b = '0;
    b.pc = pc; b.pc4 = pc + 32'd4; b.rs1_data = rs1d; b.rs2_data = rs2d; b.imm = imm;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.funct3 = f3; b.alu_op = alu;
    return b;
  endfunction

  function automatic bundle_t load_bits(input bundle_t b);
    bundle_t r;
    r = b;
    r.alu_src_imm = 1'b1; r.mem_read = 1'b1; r.reg_write = 1'b1; r.wb_sel = 2'd1;
    return r;
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, pc, input logic fl,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic cs, es, ce, input bundle_t e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; instruction = ins; PC = pc; PC_plus_4 = pc + 32'd4; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    it.chk_stall = cs; it.exp_stall = es; it.chk_ex = ce; it.exp = e; it.name = nm;
    sb_q.push_back(it);
  endtask

  // Monitor: the bundle expected from last cycle's inputs, then this cycle's stall
  initial begin
    item_t   pend;
    logic    have;
    bundle_t act;
    have = 1'b0;
    forever begin
      @(negedge clk);
      act = {ex_PC, ex_PC_plus_4, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_funct3, ex_alu_op, ex_alu_src_imm, ex_op_a_pc, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal, ex_wb_sel};
      if (have && pend.chk_ex) begin
        n_total++;
        if (act === pend.exp) n_pass++;
        else $display("FAIL %s idex: actual %h required %h", pend.name, act, pend.exp);
      end
      have = 1'b0;
      if (sb_q.size() > 0) begin
        pend = sb_q.pop_front();
        have = 1'b1;
        if (pend.chk_stall) begin
          n_total++;
          if (load_use_stall === pend.exp_stall) n_pass++;
          else $display("FAIL %s stall: actual %b required %b", pend.name,
                        load_use_stall, pend.exp_stall);
        end
      end
    end
  end

  initial begin
    bundle_t e, z;
    z = '0;
    rst = 1'b1; instruction = 32'h0000_0013; PC = 32'h0; PC_plus_4 = 32'h4;
    flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, z, "reset");

    e = mk(32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd1, 3'd0, 4'd0);
    e.alu_src_imm = 1'b1; e.reg_write = 1'b1;
    step(1'b0, 32'hFFF0_0093, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "addi_imm");

    e = mk(32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 3'd0, 4'd0);
    e.reg_write = 1'b1;
    step(1'b0, 32'h0002_8333, 32'h104, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, e, "wb_bypass");

    e = mk(32'h108, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd5, 5'd7, 3'd0, 4'd0);
    e.reg_write = 1'b1;
    step(1'b0, 32'h0050_03B3, 32'h108, 1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, e, "x0_write_bypass");

    e = mk(32'h10C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 3'd0, 4'd1);
    e.reg_write = 1'b1;
    step(1'b0, 32'h4000_0433, 32'h10C, 1'b0, 1'b1, 5'd1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, e, "x0_read_sub");

    e = load_bits(mk(32'h110, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 3'd2, 4'd0));
    step(1'b0, 32'h0000_A183, 32'h110, 1'b0, 1'b1, 5'd2, 32'h0000_0020, 1'b1, 1'b0, 1'b1, e, "load");

    step(1'b0, 32'h0021_8233, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, z, "load_use_stall");

    e = mk(32'h114, 32'h0, 32'h20, 32'h0, 5'd3, 5'd2, 5'd4, 3'd0, 4'd0);
    e.reg_write = 1'b1;
    step(1'b0, 32'h0021_8233, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "after_bubble");

    e = load_bits(mk(32'h118, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 3'd2, 4'd0));
    step(1'b0, 32'h0000_A183, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "load2");

    step(1'b0, 32'h0021_8233, 32'h11C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, z, "flush_over_stall");

    e = mk(32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0);
    e.illegal = 1'b1;
    step(1'b0, 32'h0000_0073, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "ecall");

    e = mk(32'h124, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd29, 3'd0, 4'd1);
    e.branch = 1'b1;
    step(1'b0, 32'hFE00_0EE3, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "beq_imm");

    e = mk(32'h128, 32'h0, 32'h0, 32'h1234_5000, 5'd8, 5'd3, 5'd9, 3'd5, 4'd10);
    e.alu_src_imm = 1'b1; e.reg_write = 1'b1;
    step(1'b0, 32'h1234_54B7, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "lui");

    e = load_bits(mk(32'h12C, 32'h10, 32'h0, 32'h4, 5'd1, 5'd4, 5'd0, 3'd2, 4'd0));
    step(1'b0, 32'h0040_A003, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "load_rd0");

    e = mk(32'h130, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 3'd0, 4'd0);
    e.reg_write = 1'b1;
    step(1'b0, 32'h0000_0233, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "no_stall_rd0");

    e = load_bits(mk(32'h134, 32'h10, 32'h0, 32'h4, 5'd1, 5'd4, 5'd5, 3'd2, 4'd0));
    step(1'b0, 32'h0040_A283, 32'h134, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "load_x5");

    step(1'b0, 32'hFE50_AC23, 32'h138, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, z, "store_rs2_stall");

    e = mk(32'h138, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 5'd1, 5'd5, 5'd24, 3'd2, 4'd0);
    e.alu_src_imm = 1'b1; e.mem_write = 1'b1;
    step(1'b0, 32'hFE50_AC23, 32'h138, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "store_imm");

    e = mk(32'h13C, 32'h0, 32'h10, 32'h0000_0800, 5'd0, 5'd1, 5'd1, 3'd0, 4'd0);
    e.jump = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
    step(1'b0, 32'h0010_00EF, 32'h13C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "jal_imm");

    e = load_bits(mk(32'h140, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 3'd2, 4'd0));
    step(1'b0, 32'h0000_A183, 32'h140, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, e, "load3");

    // Reset while a load sits in ID/EX and its consumer is in ID
    step(1'b1, 32'h0021_8233, 32'h144, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, z, "reset_mid");

    for (int i = 1; i < 32; i++) begin
      logic [4:0]  ri;
      logic [31:0] ins;
      ri  = 5'(i);
      ins = (32'(ri) << 20) | (32'(ri) << 15) | 32'h0000_0033;
      e = mk(32'h200 + 32'(i) * 32'd4, 32'h0, 32'h0, 32'h0, ri, ri, 5'd0, 3'd0, 4'd0);
      e.reg_write = 1'b1;
      step(1'b0, ins, 32'h200 + 32'(i) * 32'd4, 1'b0, 1'b0, 5'd0, 32'h0,
           1'b1, 1'b0, 1'b1, e, "rf_cleared");
    end

    step(1'b0, 32'h0000_0013, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, z, "idle");
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
